exec_wb_unit: RTL and testbench
===============================

Name: exec_wb_unit

Overview:
- Execute/write-back stage that sits directly downstream of the register file read ports and directly upstream of its write port.
- Accepts one operation per handshake, carrying operands a/b and a destination address.
- Computes the result: single-cycle ALU ops, plus an iterative shift-add multiply.
- Drives the register file write bundle (we/wad/wd) and pulses cwe once per retired operation, feeding the retire counter.

Parameters:
- DW, `WIDTH+1, datapath width in bits (all widths from pu.vh).
- AW, `RASB+1, register address width.
- CW, $clog2(DW+1), multiply iteration counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset: asynchronous, active-low (asserted when 0). Port names follow the codebase (clk, rst); polarity and synchronicity are fixed as stated.
- iss_valid  in  1  upstream presents an operation.
- iss_ready  out  1  unit can accept; high only in IDLE.
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1 (a<<1), 6 SHR1 (a>>1 logical), 7 MUL.
- a  in  DW  operand A, from rega port a.
- b  in  DW  operand B, from rega port b.
- dst  in  AW  destination register.
- we  out  1  register file write enable (one-cycle pulse).
- wad  out  AW  write address.
- wd  out  DW  write data.
- cwe  out  1  retire pulse; coincident with we.
- busy  out  1  high in MUL state.

Behaviour:
- Accept: an operation is taken at a rising edge where iss_valid && iss_ready. op/a/b/dst are sampled only at that edge.
- States:
  - IDLE: accept non-MUL -> stay in IDLE; accept MUL -> MUL.
  - MUL: after DW iterations -> IDLE.
- Non-MUL ops:
  - Result is registered; we/cwe are high for exactly the cycle after the accept edge, with wad=dst and wd=result.
  - Back-to-back accepts give a we pulse every cycle.
- Arithmetic:
  - Results are truncated to DW bits; carry/borrow are discarded.
  - SUB = a - b, two's complement wrap.
  - SHL1/SHR1 ignore b; a 0 is shifted in.
- MUL:
  - On accept: mcand<=a (DW bits), mplier<=b, acc<=0, cnt<=0.
  - Each MUL cycle: if mplier[0], acc<=acc+mcand (mod 2^DW); mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
  - When cnt reaches DW-1, that iteration completes, the state returns to IDLE, and we/cwe pulse the next cycle with wd=acc, wad=latched dst.
  - Latency: accept at edge N, we high in cycle N+DW+1.
  - Result is the low DW bits of a*b.
- iss_ready:
  - Equals (state==IDLE).
  - It is low throughout MUL, including the iteration cycle that returns to IDLE.
  - The cycle in which MUL's we pulse is visible is an IDLE cycle and may accept a new op.
- No forwarding: upstream must not read dst until the cycle after we. A same-cycle read returns the old value.
- we is never asserted without cwe, and vice versa.
- Reset:
  - While rst=0: state=IDLE, we=0, cwe=0, wad=0, wd=0, busy=0; iss_ready becomes 1 once rst is released.
  - Internal acc/mcand/mplier/cnt are cleared.
  - Reset during MUL aborts the operation; no write occurs.
- iss_valid held high while iss_ready=0: no accept, and no state change except MUL progress.

Optional Feature:
- EXU_FLAGS_EN defined:
  - Adds outputs zf (1) and cf (1), registered with we. They hold their value between writes and are reset to 0.
  - zf = (wd==0).
  - cf = carry out of ADD, borrow of SUB (a<b unsigned), bit shifted out for SHL1/SHR1, and OR of the discarded high product bits for MUL (overflow).
  - cf = 0 for logic ops.
- EXU_FLAGS_EN undefined: no zf/cf ports and no flag logic.

Decomposition:
- Shared package exu_pkg:
  - op encoding enum (op_t) and state enum (state_t: IDLE, MUL).
  - DW/AW-derived constants.
- One sub-module, exu_alu: purely combinational; op/a/b -> result (and carry under EXU_FLAGS_EN).
- FSM, multiply datapath and write-back registers live in the top.

Test Plan (DW=8, AW=2):
- Reset: hold rst=0 with iss_valid=1 -> we=0, cwe=0, wd=0, no accept; after release, iss_ready=1.
- ADD then SUB back-to-back: ADD a=200 b=100 dst=1, then SUB a=3 b=5 dst=2 -> we pulses two consecutive cycles, (wad=1, wd=44) then (wad=2, wd=254); cf=1 both under EXU_FLAGS_EN.
- MUL: a=13 b=11 dst=3 -> iss_ready=0 and busy=1 for 8 cycles; we exactly 9 cycles after accept with wd=143, wad=3, cwe=1; a second op presented during MUL is accepted only after iss_ready returns.
- MUL overflow: a=16 b=32 -> wd=0; zf=1 and cf=1 under EXU_FLAGS_EN.
- Reset mid-MUL: accept MUL, assert rst=0 at iteration 4 -> no we/cwe pulse ever; state=IDLE after release.
- Shifts/logic: SHL1 a=0x81 -> wd=0x02 (cf=1); SHR1 a=0x81 -> 0x40 (cf=1); XOR 0xF0^0xFF -> 0x0F; count of cwe pulses equals number of accepted ops.

Source files
------------

// File: rtl/exu_pkg.sv
// Shared types and constants for the execute/write-back unit.
// Optional flag outputs are enabled with EXU_FLAGS_EN.
package exu_pkg;

  localparam int unsigned DefDw = 8;
  localparam int unsigned DefAw = 2;

  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpAnd  = 3'd2,
    OpOr   = 3'd3,
    OpXor  = 3'd4,
    OpShl1 = 3'd5,
    OpShr1 = 3'd6,
    OpMul  = 3'd7
  } op_t;

  typedef enum logic {
    StIdle = 1'b0,
    StMul  = 1'b1
  } state_t;

  // Width of a counter that can hold the values 0..dw.
  function automatic int unsigned cnt_width(input int unsigned dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/exu_alu.sv
// Combinational single-cycle ALU; MUL is handled by the iterative datapath in the top.
// With EXU_FLAGS_EN it also reports carry/borrow/shifted-out bit.
module exu_alu
  import exu_pkg::*;
#(
  parameter int unsigned DW = DefDw
) (
  input  op_t           op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
`ifdef EXU_FLAGS_EN
  output logic          carry_o,
`endif
  output logic [DW-1:0] res_o
);

  always_comb begin
    res_o = '0;
    unique case (op_i)
      OpAdd:  res_o = a_i + b_i;
      OpSub:  res_o = a_i - b_i;
      OpAnd:  res_o = a_i & b_i;
      OpOr:   res_o = a_i | b_i;
      OpXor:  res_o = a_i ^ b_i;
      OpShl1: res_o = {a_i[DW-2:0], 1'b0};
      OpShr1: res_o = {1'b0, a_i[DW-1:1]};
      OpMul:  res_o = '0;
    endcase
  end

`ifdef EXU_FLAGS_EN
  always_comb begin
    carry_o = 1'b0;
    unique case (op_i)
      OpAdd:   carry_o = (res_o < a_i);  // wrapped sum is smaller than an addend
      OpSub:   carry_o = (a_i < b_i);
      OpShl1:  carry_o = a_i[DW-1];
      OpShr1:  carry_o = a_i[0];
      default: carry_o = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/exec_wb_unit.sv
// Execute/write-back stage: single-cycle ALU ops plus shift-add multiply, driving the
// register file write port. EXU_FLAGS_EN adds registered zf/cf outputs.
module exec_wb_unit
  import exu_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned AW = DefAw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [AW-1:0] dst,
  output logic          we,
  output logic [AW-1:0] wad,
  output logic [DW-1:0] wd,
  output logic          cwe,
`ifdef EXU_FLAGS_EN
  output logic          zf,
  output logic          cf,
`endif
  output logic          busy
);

  localparam int unsigned CW = cnt_width(DW);
  localparam logic [CW-1:0] LastIter = CW'(DW - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_add;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] dst_q, dst_d, wad_q, wad_d;
  logic [DW-1:0] wd_q, wd_d;
  logic          we_q, we_d;
  logic [DW-1:0] alu_res;
  op_t           op_e;
  logic          accept;

  assign op_e      = op_t'(op);
  assign iss_ready = (state_q == StIdle);
  assign busy      = (state_q == StMul);
  assign accept    = iss_valid && iss_ready;
  assign acc_add   = mplier_q[0] ? acc_q + mcand_q : acc_q;

`ifdef EXU_FLAGS_EN
  logic alu_carry;
  logic zf_q, zf_d, cf_q, cf_d;
  // ovf: product already exceeded DW bits; mhi: shifted multiplicand lost a set bit.
  logic ovf_q, ovf_d, mhi_q, mhi_d;
`endif

  exu_alu #(
    .DW(DW)
  ) u_alu (
    .op_i   (op_e),
    .a_i    (a),
    .b_i    (b),
`ifdef EXU_FLAGS_EN
    .carry_o(alu_carry),
`endif
    .res_o  (alu_res)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dst_d    = dst_q;
    we_d     = 1'b0;
    wad_d    = wad_q;
    wd_d     = wd_q;
`ifdef EXU_FLAGS_EN
    zf_d  = zf_q;
    cf_d  = cf_q;
    ovf_d = ovf_q;
    mhi_d = mhi_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (op_e == OpMul) begin
            state_d  = StMul;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            dst_d    = dst;
`ifdef EXU_FLAGS_EN
            ovf_d = 1'b0;
            mhi_d = 1'b0;
`endif
          end else begin
            we_d  = 1'b1;
            wad_d = dst;
            wd_d  = alu_res;
`ifdef EXU_FLAGS_EN
            zf_d = (alu_res == '0);
            cf_d = alu_carry;
`endif
          end
        end
      end
      StMul: begin
        acc_d    = acc_add;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
`ifdef EXU_FLAGS_EN
        ovf_d = ovf_q | (mplier_q[0] & (mhi_q | (acc_add < acc_q)));
        mhi_d = mhi_q | mcand_q[DW-1];
`endif
        if (cnt_q == LastIter) begin
          state_d = StIdle;
          we_d    = 1'b1;
          wad_d   = dst_q;
          wd_d    = acc_add;
`ifdef EXU_FLAGS_EN
          zf_d = (acc_add == '0);
          cf_d = ovf_d;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dst_q    <= '0;
      we_q     <= 1'b0;
      wad_q    <= '0;
      wd_q     <= '0;
`ifdef EXU_FLAGS_EN
      zf_q  <= 1'b0;
      cf_q  <= 1'b0;
      ovf_q <= 1'b0;
      mhi_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dst_q    <= dst_d;
      we_q     <= we_d;
      wad_q    <= wad_d;
      wd_q     <= wd_d;
`ifdef EXU_FLAGS_EN
      zf_q  <= zf_d;
      cf_q  <= cf_d;
      ovf_q <= ovf_d;
      mhi_q <= mhi_d;
`endif
    end
  end

  assign we  = we_q;
  assign cwe = we_q;
  assign wad = wad_q;
  assign wd  = wd_q;
`ifdef EXU_FLAGS_EN
  assign zf = zf_q;
  assign cf = cf_q;
`endif

endmodule

// File: tb/tb_exec_wb_unit.sv
// Randomised bench for exec_wb_unit with a transaction-level reference model.
// Flag checks are compiled in when EXU_FLAGS_EN is defined.
module tb_exec_wb_unit;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int Mask = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          iss_valid;
  logic          iss_ready;
  logic [2:0]    op;
  logic [DW-1:0] a, b;
  logic [AW-1:0] dst;
  logic          we, cwe, busy;
  logic [AW-1:0] wad;
  logic [DW-1:0] wd;
`ifdef EXU_FLAGS_EN
  logic          zf, cf;
`endif

  exec_wb_unit #(
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .iss_valid(iss_valid),
    .iss_ready(iss_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .dst      (dst),
    .we       (we),
    .wad      (wad),
    .wd       (wd),
    .cwe      (cwe),
`ifdef EXU_FLAGS_EN
    .zf       (zf),
    .cf       (cf),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int wad;
    int wd;
    bit zf;
    bit cf;
  } wr_t;

  wr_t pend[$];
  int  checks = 0, errors = 0;
  int  cyc = 0, free_edge = 0;
  int  accepted = 0, aborted = 0, cwe_seen = 0;
  bit  exp_zf = 1'b0, exp_cf = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Spec-level result and flag for one operation, in plain integer arithmetic.
  task automatic ref_op(input int o, input int x, input int y, output int r, output bit c);
    c = 1'b0;
    case (o)
      0: begin r = (x + y) & Mask; c = (x + y) > Mask; end
      1: begin r = (x - y) & Mask; c = x < y; end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: begin r = (x * 2) & Mask; c = x >= (1 << (DW - 1)); end
      6: begin r = x / 2; c = (x % 2) == 1; end
      default: begin r = (x * y) & Mask; c = (x * y) > Mask; end
    endcase
  endtask

  task automatic sample();
    bit ew;
    ew = (pend.size() > 0) && (pend[0].due == cyc);
    check_eq("we", 32'(we), 32'(ew));
    check_eq("cwe", 32'(cwe), 32'(ew));
    if (cwe === 1'b1) cwe_seen++;
    if (ew) begin
      check_eq("wad", 32'(wad), 32'(pend[0].wad));
      check_eq("wd", 32'(wd), 32'(pend[0].wd));
      exp_zf = pend[0].zf;
      exp_cf = pend[0].cf;
      void'(pend.pop_front());
    end
`ifdef EXU_FLAGS_EN
    check_eq("zf", 32'(zf), 32'(exp_zf));
    check_eq("cf", 32'(cf), 32'(exp_cf));
`endif
    check_eq("iss_ready", 32'(iss_ready), 32'(cyc + 1 >= free_edge));
    check_eq("busy", 32'(busy), 32'(cyc + 1 < free_edge));
  endtask

  task automatic step(input bit v, input int o, input int x, input int y, input int d);
    int  r;
    bit  c;
    wr_t w;
    @(negedge clk);
    iss_valid = v;
    op        = 3'(o);
    a         = DW'(x);
    b         = DW'(y);
    dst       = AW'(d);
    @(posedge clk);
    cyc++;
    if (v && cyc >= free_edge) begin
      ref_op(o, x, y, r, c);
      w.wad = d;
      w.wd  = r;
      w.zf  = (r == 0);
      w.cf  = c;
      if (o == 7) begin
        w.due     = cyc + DW;
        free_edge = cyc + DW + 1;
      end else begin
        w.due     = cyc;
        free_edge = cyc + 1;
      end
      pend.push_back(w);
      accepted++;
    end
    #1;
    sample();
  endtask

  task automatic reset_hold(input int n);
    @(negedge clk);
    rst       = 1'b0;
    iss_valid = 1'b1;
    op        = 3'd0;
    aborted  += pend.size();
    pend.delete();
    exp_zf = 1'b0;
    exp_cf = 1'b0;
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
      check_eq("rst_we", 32'(we), 32'd0);
      check_eq("rst_cwe", 32'(cwe), 32'd0);
      check_eq("rst_wd", 32'(wd), 32'd0);
      check_eq("rst_wad", 32'(wad), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
`ifdef EXU_FLAGS_EN
      check_eq("rst_zf", 32'(zf), 32'd0);
      check_eq("rst_cf", 32'(cf), 32'd0);
`endif
    end
    @(negedge clk);
    rst       = 1'b1;
    iss_valid = 1'b0;
    free_edge = cyc + 1;
  endtask

  initial begin
    rst       = 1'b0;
    iss_valid = 1'b1;
    op        = '0;
    a         = '0;
    b         = '0;
    dst       = '0;
    reset_hold(3);

    // ADD/SUB back-to-back, then MUL with a new op held valid throughout.
    step(1, 0, 200, 100, 1);
    step(1, 1, 3, 5, 2);
    step(1, 7, 13, 11, 3);
    repeat (10) step(1, 4, 8'hF0, 8'hFF, 0);
    // MUL overflow to zero.
    step(1, 7, 16, 32, 2);
    repeat (9) step(0, 0, 0, 0, 0);
    // Shifts and logic.
    step(1, 5, 8'h81, 0, 1);
    step(1, 6, 8'h81, 8'hFF, 2);
    step(1, 4, 8'hF0, 8'hFF, 3);
    step(1, 2, 8'hCC, 8'hAA, 0);
    step(1, 3, 8'h0C, 8'hA0, 1);

    // Abort a MUL midway: no write may ever appear.
    step(1, 7, 13, 11, 3);
    repeat (3) step(0, 0, 0, 0, 0);
    reset_hold(2);
    repeat (12) step(0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, Mask)),
           int'($urandom_range(0, Mask)), int'($urandom_range(0, (1 << AW) - 1)));
    end
    repeat (DW + 2) step(0, 0, 0, 0, 0);

    check_eq("cwe_count", 32'(cwe_seen), 32'(accepted - aborted));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
